// File: rtl/rf_writeback_arbiter_if.sv
// Signal bundle between the core writeback stage, the ML coprocessor, decode and the register file write port.
// The arbiter connects through the slave modport; the surrounding pipeline drives the master side.
interface rf_writeback_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        core_stall;
  logic        cop_valid;
  logic        cop_ready;
  logic [4:0]  cop_rd;
  logic [31:0] cop_data;
  logic [31:0] cop_pending_mask;
  logic        w_enable;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        fwd_rs1_hit;
  logic        fwd_rs2_hit;

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  cop_valid, cop_rd, cop_data,
    input  rs1_addr, rs2_addr,
    output core_stall, cop_ready, cop_pending_mask,
    output w_enable, rd_addr, rd_data,
    output fwd_rs1_hit, fwd_rs2_hit
  );

  modport master (
    output wb_valid, wb_rd, wb_data,
    output cop_valid, cop_rd, cop_data,
    output rs1_addr, rs2_addr,
    input  core_stall, cop_ready, cop_pending_mask,
    input  w_enable, rd_addr, rd_data,
    input  fwd_rs1_hit, fwd_rs2_hit
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Merges core writebacks and buffered coprocessor results onto the single register-file write port.
// Optional feature macro RF_WB_FWD_EN enables the rd_data forwarding hits; otherwise they are tied low.
module rf_writeback_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_writeback_arbiter_if.slave bus
);

  localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_CORE,
    SLOT_DRAIN,
    SLOT_STALL
  } slot_e;

  logic [4:0]       memRd_q   [DEPTH];
  logic [31:0]      memData_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [7:0]       starve_q, starve_d;

  logic             wEn_q, wEn_d;
  logic [4:0]       rdAddr_q, rdAddr_d;
  logic [31:0]      rdData_q, rdData_d;
  logic             outCop_q, outCop_d;

  slot_e            slot;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             push;
  logic             pop;
  logic [31:0]      pendMask;

  // Occupancy comes straight from the per-entry valid bits, so full/empty need no counter.
  always_comb begin
    fifoEmpty = ~|vld_q;
    fifoFull  = &vld_q;
    push      = bus.cop_valid && !fifoFull && (bus.cop_rd != 5'd0);
    slot      = SLOT_IDLE;
    if ((starve_q == STARVE_LIM) && !fifoEmpty) begin
      slot = SLOT_STALL;
    end else if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
      slot = SLOT_CORE;
    end else if (!fifoEmpty) begin
      slot = SLOT_DRAIN;
    end
    pop = (slot == SLOT_STALL) || (slot == SLOT_DRAIN);
  end

  always_comb begin
    wEn_d    = 1'b0;
    rdAddr_d = rdAddr_q;
    rdData_d = rdData_q;
    outCop_d = 1'b0;
    unique case (slot)
      SLOT_CORE: begin
        wEn_d    = 1'b1;
        rdAddr_d = bus.wb_rd;
        rdData_d = bus.wb_data;
      end
      SLOT_DRAIN, SLOT_STALL: begin
        wEn_d    = 1'b1;
        rdAddr_d = memRd_q[rdPtr_q];
        rdData_d = memData_q[rdPtr_q];
        outCop_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Push and pop never target the same slot: that would need a full FIFO, which refuses pushes.
  always_comb begin
    vld_d   = vld_q;
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    if (pop) begin
      vld_d[rdPtr_q] = 1'b0;
      rdPtr_d        = rdPtr_q + 1'b1;
    end
    if (push) begin
      vld_d[wrPtr_q] = 1'b1;
      wrPtr_d        = wrPtr_q + 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || fifoEmpty) begin
      starve_d = 8'd0;
    end else if ((slot == SLOT_CORE) && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      rdPtr_q  <= '0;
      wrPtr_q  <= '0;
      starve_q <= '0;
      wEn_q    <= 1'b0;
      rdAddr_q <= '0;
      rdData_q <= '0;
      outCop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        memRd_q[i]   <= '0;
        memData_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      rdPtr_q  <= rdPtr_d;
      wrPtr_q  <= wrPtr_d;
      starve_q <= starve_d;
      wEn_q    <= wEn_d;
      rdAddr_q <= rdAddr_d;
      rdData_q <= rdData_d;
      outCop_q <= outCop_d;
      if (push) begin
        memRd_q[wrPtr_q]   <= bus.cop_rd;
        memData_q[wrPtr_q] <= bus.cop_data;
      end
    end
  end

  // A coprocessor write stays pending until it actually leaves the output register.
  always_comb begin
    pendMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) begin
        pendMask[memRd_q[i]] = 1'b1;
      end
    end
    if (wEn_q && outCop_q) begin
      pendMask[rdAddr_q] = 1'b1;
    end
    pendMask[0] = 1'b0;
  end

  assign bus.cop_ready        = !fifoFull;
  assign bus.core_stall       = (slot == SLOT_STALL);
  assign bus.cop_pending_mask = pendMask;
  assign bus.w_enable         = wEn_q;
  assign bus.rd_addr          = rdAddr_q;
  assign bus.rd_data          = rdData_q;

`ifdef RF_WB_FWD_EN
  assign bus.fwd_rs1_hit = wEn_q && (rdAddr_q != 5'd0) && (bus.rs1_addr == rdAddr_q);
  assign bus.fwd_rs2_hit = wEn_q && (rdAddr_q != 5'd0) && (bus.rs2_addr == rdAddr_q);
`else
  logic unusedRsAddr;
  assign unusedRsAddr    = ^{bus.rs1_addr, bus.rs2_addr};
  assign bus.fwd_rs1_hit = 1'b0;
  assign bus.fwd_rs2_hit = 1'b0;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based behavioural model.
module tb_rf_writeback_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;
`ifdef RF_WB_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rf_writeback_arbiter_if bus();

  rf_writeback_arbiter #(
    .DEPTH     (DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  // Behavioural model: an ordered queue of pending results plus the visible write-port register.
  entry_t      modelQ[$];
  int          modelStarve;
  logic        modelWe;
  logic [4:0]  modelAddr;
  logic [31:0] modelData;
  logic        modelCop;

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  function automatic void modelReset();
    modelQ.delete();
    modelStarve = 0;
    modelWe     = 1'b0;
    modelAddr   = 5'd0;
    modelData   = 32'd0;
    modelCop    = 1'b0;
  endfunction

  function automatic logic modelStallNow();
    return (modelStarve == STARVE_MAX) && (modelQ.size() != 0);
  endfunction

  function automatic logic [31:0] modelMask();
    logic [31:0] m;
    m = '0;
    foreach (modelQ[i]) m[modelQ[i].rd] = 1'b1;
    if (modelWe && modelCop) m[modelAddr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic modelFwd(input logic [4:0] rs);
    return FWD_ON && modelWe && (modelAddr != 5'd0) && (rs == modelAddr);
  endfunction

  // Advance the model across one rising edge using the inputs currently presented.
  function automatic void modelStep();
    logic   wasFull;
    logic   wasEmpty;
    logic   coreWants;
    logic   popped;
    logic   coreWin;
    entry_t head;
    wasFull   = (modelQ.size() >= DEPTH);
    wasEmpty  = (modelQ.size() == 0);
    coreWants = bus.wb_valid && (bus.wb_rd != 5'd0);
    popped    = 1'b0;
    coreWin   = 1'b0;
    if (modelStallNow() || (!wasEmpty && !coreWants)) begin
      head      = modelQ.pop_front();
      modelWe   = 1'b1;
      modelAddr = head.rd;
      modelData = head.data;
      modelCop  = 1'b1;
      popped    = 1'b1;
    end else if (coreWants) begin
      modelWe   = 1'b1;
      modelAddr = bus.wb_rd;
      modelData = bus.wb_data;
      modelCop  = 1'b0;
      coreWin   = 1'b1;
    end else begin
      modelWe  = 1'b0;
      modelCop = 1'b0;
    end
    if (popped || wasEmpty) modelStarve = 0;
    else if (coreWin) modelStarve = (modelStarve + 1 > STARVE_MAX) ? STARVE_MAX : modelStarve + 1;
    if (bus.cop_valid && !wasFull && (bus.cop_rd != 5'd0)) modelQ.push_back({bus.cop_rd, bus.cop_data});
  endfunction

  task automatic checkOutput();
    check("w_enable",     64'(bus.w_enable),         64'(modelWe));
    check("rd_addr",      64'(bus.rd_addr),          64'(modelAddr));
    check("rd_data",      64'(bus.rd_data),          64'(modelData));
    check("cop_ready",    64'(bus.cop_ready),        64'(modelQ.size() < DEPTH));
    check("core_stall",   64'(bus.core_stall),       64'(modelStallNow()));
    check("pending_mask", 64'(bus.cop_pending_mask), 64'(modelMask()));
    check("fwd_rs1_hit",  64'(bus.fwd_rs1_hit),      64'(modelFwd(bus.rs1_addr)));
    check("fwd_rs2_hit",  64'(bus.fwd_rs2_hit),      64'(modelFwd(bus.rs2_addr)));
  endtask

  task automatic applyStimulus(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                               input logic cv, input logic [4:0] crd, input logic [31:0] cd,
                               input logic [4:0] r1, input logic [4:0] r2);
    bus.wb_valid  = wv;
    bus.wb_rd     = wrd;
    bus.wb_data   = wd;
    bus.cop_valid = cv;
    bus.cop_rd    = crd;
    bus.cop_data  = cd;
    bus.rs1_addr  = r1;
    bus.rs2_addr  = r2;
    #1;
    checkOutput();
  endtask

  task automatic clockEdge();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    clockEdge();
  endtask

  task automatic checkResetLiterals(input string tag);
    check({tag, "_w_enable"},   64'(bus.w_enable),         64'd0);
    check({tag, "_rd_addr"},    64'(bus.rd_addr),          64'd0);
    check({tag, "_rd_data"},    64'(bus.rd_data),          64'd0);
    check({tag, "_cop_ready"},  64'(bus.cop_ready),        64'd1);
    check({tag, "_core_stall"}, 64'(bus.core_stall),       64'd0);
    check({tag, "_mask"},       64'(bus.cop_pending_mask), 64'd0);
    check({tag, "_fwd1"},       64'(bus.fwd_rs1_hit),      64'd0);
    check({tag, "_fwd2"},       64'(bus.fwd_rs2_hit),      64'd0);
  endtask

  initial begin
    int   pushed;
    int   stallCycle;
    int   stallCount;
    int   firstBlocked;
    int   readyAgain;
    logic holdWb;
    logic wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic cv;
    logic [4:0]  crd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    int   wbPct;

    // Power-on reset with idle inputs.
    rst_n         = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
    bus.cop_valid = 1'b0;
    bus.cop_rd    = 5'd0;
    bus.cop_data  = 32'd0;
    bus.rs1_addr  = 5'd0;
    bus.rs2_addr  = 5'd0;
    #1;
    rst_n = 1'b0;
    #1;
    checkResetLiterals("por");
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Core write x5 lands on the port one edge later and is forwardable.
    $display("[TB] core write to x5");
    applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("x5_w_enable", 64'(bus.w_enable),    64'd1);
    check("x5_rd_addr",  64'(bus.rd_addr),     64'd5);
    check("x5_rd_data",  64'(bus.rd_data),     64'h1234_5678);
    check("x5_fwd_rs1",  64'(bus.fwd_rs1_hit), 64'(FWD_ON));
    clockEdge();

    // Four coprocessor results buffered behind core writes to x20, then drained in order.
    $display("[TB] coprocessor burst x1..x4");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'd20, 32'(i * 100), 1'b1, 5'(i), 32'hC000_0000 + 32'(i), 5'd0, 5'd0);
      clockEdge();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("burst_mask_full", 64'(bus.cop_pending_mask), 64'h1E);
    clockEdge();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      check("burst_drain_wen",  64'(bus.w_enable), 64'd1);
      check("burst_drain_addr", 64'(bus.rd_addr),  64'(i));
      check("burst_drain_data", 64'(bus.rd_data),  64'hC000_0000 + 64'(i));
      clockEdge();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("burst_mask_clear", 64'(bus.cop_pending_mask), 64'd0);
    check("burst_idle_wen",   64'(bus.w_enable),         64'd0);
    clockEdge();

    // Coprocessor result to x0 is swallowed; core write to x0 lets the FIFO head drain.
    $display("[TB] x0 handling");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    check("x0cop_ready", 64'(bus.cop_ready), 64'd1);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("x0cop_mask", 64'(bus.cop_pending_mask), 64'd0);
    check("x0cop_wen",  64'(bus.w_enable),         64'd0);
    clockEdge();
    applyStimulus(1'b1, 5'd20, 32'd1, 1'b1, 5'd3, 32'h0000_0033, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("x0core_drain_wen",  64'(bus.w_enable), 64'd1);
    check("x0core_drain_addr", 64'(bus.rd_addr),  64'd3);
    check("x0core_drain_data", 64'(bus.rd_data),  64'h33);
    clockEdge();

    // Core writes every cycle while five results arrive: FIFO fills, then the starvation guard fires.
    $display("[TB] starvation guard");
    pushed       = 0;
    stallCycle   = -1;
    stallCount   = 0;
    firstBlocked = -1;
    readyAgain   = -1;
    for (int c = 1; c <= 14; c++) begin
      applyStimulus(1'b1, 5'd21, 32'hABCD_0000, pushed < 5, 5'(pushed + 1), 32'h5000_0000 + 32'(pushed),
                    5'd0, 5'd0);
      if (bus.core_stall) begin
        stallCount++;
        if (stallCycle < 0) stallCycle = c;
      end
      if (!bus.cop_ready && firstBlocked < 0) firstBlocked = c;
      if (bus.cop_ready && firstBlocked > 0 && readyAgain < 0) readyAgain = c;
      if (bus.cop_valid && bus.cop_ready) pushed++;
      clockEdge();
    end
    check("starve_first_blocked", 64'(firstBlocked), 64'd5);
    check("starve_stall_cycle",   64'(stallCycle),   64'd10);
    check("starve_stall_count",   64'(stallCount),   64'd1);
    check("starve_ready_again",   64'(readyAgain),   64'd11);
    for (int i = 0; i < 6; i++) idleCycle();

    // Asynchronous reset with three results buffered and a write on the port.
    $display("[TB] mid-operation reset");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd22, 32'h2200_0000 + 32'(i), i < 3, 5'(9 + i), 32'h9900_0000 + 32'(i),
                    5'd22, 5'd9);
      clockEdge();
    end
    applyStimulus(1'b1, 5'd22, 32'h2200_0004, 1'b0, 5'd0, 32'd0, 5'd22, 5'd9);
    check("prereset_wen",  64'(bus.w_enable),         64'd1);
    check("prereset_mask", 64'(bus.cop_pending_mask), 64'h0E00);
    rst_n = 1'b0;
    #1;
    checkResetLiterals("async");
    modelReset();
    @(posedge clk);
    #1;
    checkResetLiterals("held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idleCycle();

    // Randomized traffic in phases of heavy, medium and light core load.
    $display("[TB] random traffic");
    holdWb = 1'b0;
    wv     = 1'b0;
    wrd    = 5'd0;
    wd     = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      wbPct = ((n / 500) % 3 == 0) ? 95 : (((n / 500) % 3 == 1) ? 50 : 10);
      if (!holdWb) begin
        wv  = ($urandom_range(0, 99) < wbPct);
        wrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wd  = $urandom;
      end
      cv  = ($urandom_range(0, 99) < 45);
      crd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r1  = ($urandom_range(0, 1) == 0) ? modelAddr : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 2) == 0) ? modelAddr : 5'($urandom_range(0, 31));
      holdWb = modelStallNow() && wv;
      applyStimulus(wv, wrd, wd, cv, crd, $urandom, r1, r2);
      clockEdge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
